// File: rtl/apb_exe_pkg.sv
// apb_exe_pkg: shared constants and types for the APB front-end of
// execution unit 1.
//   - register byte addresses (decoded on PADDR[4:0])
//   - CTRL start bit and STATUS bit positions
//   - exec FSM state type and the decoded-access struct used by the top
package apb_exe_pkg;

  localparam logic [4:0] ADDR_A      = 5'h00;
  localparam logic [4:0] ADDR_B      = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_STATUS = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;

  localparam int CTRL_START_BIT = 8;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic {
    E_IDLE = 1'b0,
    E_RUN  = 1'b1
  } exe_state_t;

  // One APB transfer, decoded for the current cycle.
  typedef struct packed {
    logic acc;   // ACCESS phase
    logic rd;    // read ACCESS
    logic wr;    // write ACCESS
    logic bad;   // transfer would be answered with PSLVERR
  } apb_dec_t;

endpackage

// File: rtl/exe_seq.sv
// exe_seq: exec FSM and latency counter.
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : accepted start command (only honoured in E_IDLE)
//   alu_error   : execution unit error, sampled on the capture edge
//   busy        : operation in flight
//   done        : sticky, set on capture, cleared by the next start
//   err         : sticky copy of alu_error from the last capture
//   capture     : strobe, high in the cycle whose closing edge captures
module exe_seq
  import apb_exe_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic alu_error,
  output logic busy,
  output logic done,
  output logic err,
  output logic capture
);

  localparam int CW = 4;

  exe_state_t    state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= E_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        E_IDLE: if (start) begin
          state <= E_RUN;
          busy  <= 1'b1;
          done  <= 1'b0;
          err   <= 1'b0;
          cnt   <= CW'(LAT - 1);
        end
        E_RUN: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          state <= E_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          err   <= alu_error;
        end
        default: state <= E_IDLE;
      endcase
    end
  end

  // Last RUN cycle: the top loads RESULT on the same edge the FSM leaves RUN.
  assign capture = (state == E_RUN) && (cnt == '0);

endmodule

// File: rtl/apb_exe_slave.sv
// apb_exe_slave: APB3 slave holding operands/op-select for execution unit 1
// and capturing its result after a fixed latency.
//   PCLK, PRESETn        : clock, synchronous active-low reset
//   PSEL..PWDATA         : APB3 request
//   PRDATA/PREADY/PSLVERR: APB3 response (PREADY low only on RESULT read
//                          while busy)
//   alu_a/alu_b/alu_op   : register outputs to the combinational unit
//   alu_result/alu_error : unit outputs, captured LAT cycles after start
module apb_exe_slave
  import apb_exe_pkg::*;
#(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LAT    = 1
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [2:0]        alu_op,
  input  logic [N-1:0]      alu_result,
  input  logic              alu_error
);

  logic [4:0]   addr;
  logic         mapped;
  apb_dec_t     dec;
  logic         wr_ok;
  logic         start;
  logic         busy, done, xerr, capture;
  logic [N-1:0] result_q;

  assign addr = PADDR[4:0];

  always_comb begin
    case (addr)
      ADDR_A, ADDR_B, ADDR_CTRL, ADDR_STATUS, ADDR_RESULT: mapped = 1'b1;
      default:                                             mapped = 1'b0;
    endcase
  end

  // Any mapped write while busy is rejected; writes to STATUS/RESULT always are.
  assign dec.acc = PSEL & PENABLE;
  assign dec.rd  = dec.acc & ~PWRITE;
  assign dec.wr  = dec.acc &  PWRITE;
  assign dec.bad = ~mapped |
                   (PWRITE & ((addr == ADDR_STATUS) | (addr == ADDR_RESULT) | busy));

  assign PREADY  = ~(dec.rd & (addr == ADDR_RESULT) & busy);
  assign PSLVERR = dec.acc & PREADY & dec.bad;
  assign wr_ok   = dec.wr & PREADY & ~dec.bad;
  assign start   = wr_ok & (addr == ADDR_CTRL) & PWDATA[CTRL_START_BIT];

  exe_seq #(.LAT(LAT)) u_seq (
    .clk       (PCLK),
    .rst_n     (PRESETn),
    .start     (start),
    .alu_error (alu_error),
    .busy      (busy),
    .done      (done),
    .err       (xerr),
    .capture   (capture)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      result_q <= '0;
    end else begin
      if (wr_ok && addr == ADDR_A)    alu_a  <= PWDATA[N-1:0];
      if (wr_ok && addr == ADDR_B)    alu_b  <= PWDATA[N-1:0];
      if (wr_ok && addr == ADDR_CTRL) alu_op <= PWDATA[2:0];
      if (capture)                    result_q <= alu_error ? '0 : alu_result;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (dec.rd && !dec.bad) begin
      case (addr)
        ADDR_A:      PRDATA[N-1:0] = alu_a;
        ADDR_B:      PRDATA[N-1:0] = alu_b;
        ADDR_CTRL:   PRDATA[2:0]   = alu_op;
        ADDR_STATUS: begin
          PRDATA[ST_BUSY] = busy;
          PRDATA[ST_DONE] = done;
          PRDATA[ST_ERR]  = xerr;
        end
        ADDR_RESULT: PRDATA = DATA_W'($signed(result_q));
        default:     PRDATA = '0;
      endcase
    end
  end

  // Only some PWDATA/PADDR bits are decoded; fold the rest into a sink.
  logic unused_bits;
  assign unused_bits = ^{1'b0, PWDATA, PADDR};

endmodule

// File: tb/tb_apb_exe_slave.sv
// tb_apb_exe_slave: two DUTs (LAT=1 and LAT=4) on a shared APB bus with
// separate selects. A timestamp-based register model predicts every
// response each cycle; directed transfers pin literal values.
module tb_apb_exe_slave;

  localparam int LATS [2] = '{1, 4};

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  psel;
  logic        PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [7:0]  alu_a [2], alu_b [2], alu_res [2];
  logic [2:0]  alu_op [2];
  logic        alu_err [2];

  int checks   = 0;
  int failures = 0;

  always #5 PCLK = ~PCLK;

  // Execution unit stand-in: sign-preserving left shift; negative count errors
  // and drives junk on the result to show the slave zeroes it.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b);
    logic [6:0] lo;
    if (b[7]) return {1'b1, 8'h5A};
    lo = a[6:0] << b;
    return {1'b0, a[7], lo};
  endfunction

  assign {alu_err[0], alu_res[0]} = alu_f(alu_a[0], alu_b[0]);
  assign {alu_err[1], alu_res[1]} = alu_f(alu_a[1], alu_b[1]);

  apb_exe_slave #(.N(8), .DATA_W(32), .ADDR_W(5), .LAT(1)) u_l1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]), .alu_a(alu_a[0]),
    .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_result(alu_res[0]),
    .alu_error(alu_err[0]));

  apb_exe_slave #(.N(8), .DATA_W(32), .ADDR_W(5), .LAT(4)) u_l4 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]), .alu_a(alu_a[1]),
    .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_result(alu_res[1]),
    .alu_error(alu_err[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Busy is "now is before the capture timestamp"; capture happens when the
  // edge count reaches that timestamp.
  logic [7:0] m_a [2], m_b [2], m_res [2];
  logic [2:0] m_op [2];
  logic       m_done [2], m_err [2];
  int         m_cap [2];
  int         cyc = 0;
  bit         m_valid = 1'b0;

  task automatic step_model(input int i);
    logic        busy, acc, rdy, bad, mapped;
    logic [31:0] exp_rd;
    logic [8:0]  f;
    string       tag;
    tag    = $sformatf("L%0d", LATS[i]);
    busy   = (cyc < m_cap[i]);
    acc    = psel[i] & PENABLE;
    mapped = (PADDR == 5'h00) || (PADDR == 5'h04) || (PADDR == 5'h08) ||
             (PADDR == 5'h0C) || (PADDR == 5'h10);
    rdy    = !(acc && !PWRITE && PADDR == 5'h10 && busy);
    bad    = !mapped || (PWRITE && (PADDR == 5'h0C || PADDR == 5'h10 || busy));
    exp_rd = 32'h0;
    if (acc && !PWRITE && !bad) begin
      case (PADDR)
        5'h00:   exp_rd = {24'h0, m_a[i]};
        5'h04:   exp_rd = {24'h0, m_b[i]};
        5'h08:   exp_rd = {29'h0, m_op[i]};
        5'h0C:   exp_rd = {29'h0, m_err[i], m_done[i], busy};
        default: exp_rd = {{24{m_res[i][7]}}, m_res[i]};
      endcase
    end
    if (m_valid) begin
      chk({tag, " pready"},  {31'h0, pready[i]},  {31'h0, rdy});
      chk({tag, " pslverr"}, {31'h0, pslverr[i]}, {31'h0, acc & rdy & bad});
      if (rdy) chk({tag, " prdata"}, prdata[i], exp_rd);
      chk({tag, " alu_a"},  {24'h0, alu_a[i]},  {24'h0, m_a[i]});
      chk({tag, " alu_b"},  {24'h0, alu_b[i]},  {24'h0, m_b[i]});
      chk({tag, " alu_op"}, {29'h0, alu_op[i]}, {29'h0, m_op[i]});
    end
    if (!PRESETn) begin
      m_a[i] = 0; m_b[i] = 0; m_op[i] = 0; m_res[i] = 0;
      m_done[i] = 0; m_err[i] = 0; m_cap[i] = 0;
    end else begin
      if (cyc + 1 == m_cap[i]) begin
        f = alu_f(m_a[i], m_b[i]);
        m_err[i]  = f[8];
        m_res[i]  = f[8] ? 8'h00 : f[7:0];
        m_done[i] = 1'b1;
      end
      if (acc && rdy && PWRITE && !bad) begin
        case (PADDR)
          5'h00: m_a[i] = PWDATA[7:0];
          5'h04: m_b[i] = PWDATA[7:0];
          default: begin
            m_op[i] = PWDATA[2:0];
            if (PWDATA[8]) begin
              m_done[i] = 1'b0;
              m_err[i]  = 1'b0;
              m_cap[i]  = cyc + 1 + LATS[i];
            end
          end
        endcase
      end
    end
  endtask

  always @(negedge PCLK) begin
    step_model(0);
    step_model(1);
    if (!PRESETn) m_valid = 1'b1;
    cyc = cyc + 1;
  end

  // ---------------- directed stimulus ----------------
  task automatic xfer(input int inst, input bit w, input logic [4:0] a,
                      input logic [31:0] d, output logic [31:0] rd,
                      output logic e, output int waits);
    psel = 2'b00; psel[inst] = 1'b1;
    PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    waits = 0;
    @(negedge PCLK);
    while (!pready[inst] && waits < 20) begin
      waits++;
      @(negedge PCLK);
    end
    if (waits >= 20) chk("xfer timeout", 32'(waits), 32'd0);
    rd = prdata[inst];
    e  = pslverr[inst];
    @(posedge PCLK); #1;
    psel = 2'b00; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd_chk(input int inst, input logic [4:0] a, input logic [31:0] exp,
                        input logic exp_e, input string name);
    logic [31:0] rd; logic e; int w;
    xfer(inst, 1'b0, a, 32'h0, rd, e, w);
    chk({name, " data"}, rd, exp);
    chk({name, " slverr"}, {31'h0, e}, {31'h0, exp_e});
  endtask

  task automatic wr_chk(input int inst, input logic [4:0] a, input logic [31:0] d,
                        input logic exp_e, input string name);
    logic [31:0] rd; logic e; int w;
    xfer(inst, 1'b1, a, d, rd, e, w);
    chk({name, " slverr"}, {31'h0, e}, {31'h0, exp_e});
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          w;
    logic [4:0]  addrs [5];
    addrs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
    psel = 2'b00; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    // 1: everything reads zero after reset, zero-wait
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 5; k++) begin
        xfer(i, 1'b0, addrs[k], 32'h0, rd, e, w);
        chk("rst data", rd, 32'h0);
        chk("rst slverr", {31'h0, e}, 32'h0);
        chk("rst waits", 32'(w), 32'h0);
      end

    // 2: LAT=1 shift 0x85 by 1; STATUS read chained onto the start access
    wr_chk(0, 5'h00, 32'h85, 1'b0, "t2 A");
    wr_chk(0, 5'h04, 32'h01, 1'b0, "t2 B");
    psel = 2'b01; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h08; PWDATA = 32'h100;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PWRITE = 1'b0; PADDR = 5'h0C;
    @(negedge PCLK);
    chk("t2 status busy", prdata[0], 32'h1);
    @(posedge PCLK); #1 psel = 2'b00; PENABLE = 1'b0;
    xfer(0, 1'b0, 5'h10, 32'h0, rd, e, w);
    chk("t2 result", rd, 32'hFFFF_FF8A);
    chk("t2 stall<=1", {31'h0, (w <= 1)}, 32'h1);
    rd_chk(0, 5'h0C, 32'h2, 1'b0, "t2 status done");

    // 3: negative shift count -> error captured, RESULT zeroed
    wr_chk(0, 5'h00, 32'h10, 1'b0, "t3 A");
    wr_chk(0, 5'h04, 32'hFF, 1'b0, "t3 B");
    wr_chk(0, 5'h08, 32'h100, 1'b0, "t3 start");
    rd_chk(0, 5'h10, 32'h0, 1'b0, "t3 result");
    rd_chk(0, 5'h0C, 32'h6, 1'b0, "t3 status");

    // 4: LAT=4, write during busy rejected; RESULT read stalls 3 cycles
    wr_chk(1, 5'h00, 32'h11, 1'b0, "t4 A");
    wr_chk(1, 5'h04, 32'h02, 1'b0, "t4 B");
    wr_chk(1, 5'h08, 32'h103, 1'b0, "t4 start1");
    wr_chk(1, 5'h00, 32'h33, 1'b1, "t4 busy wr");
    rd_chk(1, 5'h00, 32'h11, 1'b0, "t4 A kept");
    rd_chk(1, 5'h08, 32'h3, 1'b0, "t4 op");
    wr_chk(1, 5'h08, 32'h100, 1'b0, "t4 start2");
    xfer(1, 1'b0, 5'h10, 32'h0, rd, e, w);
    chk("t4 stall", 32'(w), 32'd3);
    chk("t4 result", rd, 32'h44);
    rd_chk(1, 5'h0C, 32'h2, 1'b0, "t4 status");

    // 5: address / access errors
    rd_chk(1, 5'h14, 32'h0, 1'b1, "t5 rd 14");
    rd_chk(1, 5'h02, 32'h0, 1'b1, "t5 rd 02");
    wr_chk(1, 5'h10, 32'hAA, 1'b1, "t5 wr 10");
    wr_chk(1, 5'h0C, 32'h7, 1'b1, "t5 wr 0C");
    rd_chk(1, 5'h10, 32'h44, 1'b0, "t5 result kept");
    rd_chk(1, 5'h0C, 32'h2, 1'b0, "t5 status kept");

    // 6: reset mid-run aborts the operation
    wr_chk(1, 5'h08, 32'h105, 1'b0, "t6 start");
    PRESETn = 1'b0;
    @(posedge PCLK); #1 PRESETn = 1'b1;
    rd_chk(1, 5'h0C, 32'h0, 1'b0, "t6 status");
    for (int k = 0; k < 3; k++) rd_chk(1, addrs[k], 32'h0, 1'b0, "t6 reg");
    rd_chk(1, 5'h10, 32'h0, 1'b0, "t6 result");
    repeat (8) @(posedge PCLK);
    #1;
    rd_chk(1, 5'h0C, 32'h0, 1'b0, "t6 no capture");
    rd_chk(1, 5'h10, 32'h0, 1'b0, "t6 result late");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_exe_slave.md
Name: apb_exe_slave

Overview:
APB3 slave front-end for execution unit 1. It holds operand and op-select registers and drives them to the combinational execution unit, which contains the shift units. After a start command it waits a fixed latency, then captures the unit's result and error into APB-readable registers. Reads of RESULT stall with PREADY low while an operation is in flight.

Parameters:
N, 8, operand/result width (signed, two's complement)
DATA_W, 32, APB data width (N <= DATA_W)
ADDR_W, 5, APB address width
LAT, 1, cycles from start acceptance to result capture (1..15)

Ports:
PCLK  in  1  APB clock, all logic rising-edge
PRESETn  in  1  reset, synchronous, active-low
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_W  byte address
PWDATA  in  DATA_W  write data
PRDATA  out  DATA_W  read data
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error
alu_a  out  N  operand A register to execution unit
alu_b  out  N  operand B register to execution unit
alu_op  out  3  op-select register to execution unit
alu_result  in  N  execution unit result
alu_error  in  1  execution unit error (e.g. negative shift count)

Behaviour:
- Reset (PRESETn=0 at PCLK edge): A, B, OP, RESULT, done, error, busy and the counter all go to 0; exec FSM goes to E_IDLE. After reset: PRDATA=0, PREADY=1, PSLVERR=0. Reset mid-operation aborts the operation; no capture occurs.
- Address map (PADDR[4:0]): 0x00 A (RW, bits[N-1:0]); 0x04 B (RW); 0x08 CTRL (bits[2:0] OP RW; bit 8 START, write-1, reads 0); 0x0C STATUS (RO: bit0 busy, bit1 done, bit2 error); 0x10 RESULT (RO, sign-extended to DATA_W).
- APB phases: SETUP = PSEL & !PENABLE; ACCESS = PSEL & PENABLE. Register side effects happen only at the edge ending an ACCESS cycle with PREADY=1.
- PREADY=0 only in ACCESS, on a read of 0x10, while busy=1. Otherwise PREADY=1. All other transfers are zero-wait.
- PSLVERR=1 only in ACCESS with PREADY=1, for any of:
  - unmapped or misaligned address (PADDR[1:0]!=0)
  - write to 0x0C or 0x10
  - write to 0x00, 0x04 or 0x08 while busy=1
  An error write changes no state. An error read returns PRDATA=0.
- PRDATA is driven from the registers during a read ACCESS and is 0 otherwise. A/B read back zero-extended.
- Exec FSM:
  - E_IDLE: an accepted CTRL write with PWDATA[8]=1 loads OP from PWDATA[2:0] in the same edge, sets busy=1, done=0, error=0, cnt=LAT-1, and moves to E_RUN.
  - E_RUN: if cnt!=0, decrement. If cnt==0, capture RESULT = alu_error ? 0 : alu_result, error = alu_error, done=1, busy=0, and return to E_IDLE.
  - A CTRL write with PWDATA[8]=0 updates OP only; no start.
- Latency: start accepted at edge t; capture at edge t+LAT; busy=1 for exactly LAT cycles.
- A stalled RESULT read completes in the first cycle after capture (busy=0) and returns the new value.
- Start and capture cannot coincide, because writes are rejected while busy.
- done and error are sticky until the next start.
- alu_a, alu_b, alu_op are direct register outputs and are stable for the whole of E_RUN.

Decomposition:
- Package apb_exe_pkg:
  - address constants ADDR_A/B/CTRL/STATUS/RESULT
  - CTRL_START_BIT = 8
  - typedef enum {E_IDLE, E_RUN} exe_state_t
  - status bit indices
- One sub-module, exe_seq: exec FSM plus latency counter. Inputs start and alu_error; outputs busy, done, capture strobe.
- APB decode and the register file stay in the top level.

Test Plan:
1. Reset, then read 0x00, 0x04, 0x08, 0x0C, 0x10 -> every read returns 0, PREADY=1, PSLVERR=0.
2. Bench models a left shift. Write A=0x85, B=0x01, CTRL=0x100 (LAT=1) -> STATUS reads 0x1 one cycle after start. An immediate RESULT read stalls 0 or 1 cycles, then returns 0xFFFFFF8A; STATUS then reads 0x2.
3. A=0x10, B=0xFF, start -> error captured. RESULT=0, STATUS=0x6, PSLVERR=0.
4. LAT=4: start, then write A=0x33 during busy -> PSLVERR=1, A still reads its old value. RESULT read holds PREADY=0 for 3 ACCESS cycles.
5. Read 0x14, read 0x02, write 0x10 and write 0x0C -> each gives PSLVERR=1 and PRDATA=0; no register changes.
6. Drive PRESETn=0 for one edge during E_RUN (LAT=4) -> next cycle busy=0, done=0, A=B=OP=RESULT=0; no later capture occurs.
